snitch_icache_lookup_arbiter: RTL and testbench

// Shares one parallel-lookup stage between NR_PORTS L0 fetch requesters.
// - Round-robin arbitration onto the lookup request port; the winning port index is appended to the ID.
// - Lookup responses are routed back to the issuing port by that index.
// - Outstanding lookups are bounded and counted.
// - Flush is sequenced: drain in-flight lookups, then forward the flush to the lookup stage.
// - Sits between the L0 caches and the lookup stage, inside the L1 icache.

---
 rtl/snitch_icache_pkg.sv | 32 +++
 rtl/snitch_icache_rr_arb.sv | 61 ++++++
 rtl/snitch_icache_lookup_arbiter.sv | 145 ++++++++++++++
 tb/tb_snitch_icache_lookup_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snitch_icache_pkg.sv
// Shared constants and types for the L1 icache lookup arbiter.
// Default configuration plus width helpers for arbitrary port counts.
package snitch_icache_pkg;

    localparam int unsigned NR_PORTS_DEF        = 4;
    localparam int unsigned FETCH_AW_DEF        = 32;
    localparam int unsigned ID_WIDTH_DEF        = 2;
    localparam int unsigned LINE_WIDTH_DEF      = 128;
    localparam int unsigned SET_ALIGN_DEF       = 2;
    localparam int unsigned MAX_OUTSTANDING_DEF = 2;

    // Port index width; one bit minimum so the ID append never collapses.
    function automatic int unsigned port_aw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

    localparam int unsigned PORT_AW = port_aw(NR_PORTS_DEF);
    localparam int unsigned LKP_IDW = ID_WIDTH_DEF + PORT_AW;
    localparam int unsigned CNT_W   = cnt_w(MAX_OUTSTANDING_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } flush_state_e;

endpackage

// File: rtl/snitch_icache_rr_arb.sv
// Round-robin picker with a grant lock that holds the winner stable
// while the downstream port stalls a presented request.
module snitch_icache_rr_arb
    import snitch_icache_pkg::*;
#(
    parameter int unsigned  NR_PORTS = NR_PORTS_DEF,
    localparam int unsigned PAW      = port_aw(NR_PORTS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [NR_PORTS-1:0] valid_i,
    input  logic                stall_i,
    input  logic                hs_i,
    output logic                valid_o,
    output logic [NR_PORTS-1:0] gnt_o,
    output logic [PAW-1:0]      idx_o
);

    logic [PAW-1:0] rr_ptr_q, grant_q, pick;
    logic           lock_q, found;
    int unsigned    j;

    // First requester at or after rr_ptr_q, scanning cyclically.
    always_comb begin
        pick  = rr_ptr_q;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            j = 32'(rr_ptr_q) + i;
            if (j >= NR_PORTS) j = j - NR_PORTS;
            if (!found && valid_i[PAW'(j)]) begin
                found = 1'b1;
                pick  = PAW'(j);
            end
        end
    end

    assign idx_o   = lock_q ? grant_q : pick;
    assign valid_o = en_i & (lock_q ? valid_i[grant_q] : found);

    always_comb begin
        gnt_o = '0;
        if (valid_o) gnt_o[idx_o] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            grant_q  <= '0;
            lock_q   <= 1'b0;
        end else if (hs_i) begin
            lock_q   <= 1'b0;
            rr_ptr_q <= (idx_o == PAW'(NR_PORTS - 1)) ? '0 : idx_o + PAW'(1);
        end else if (stall_i) begin
            lock_q   <= 1'b1;
            grant_q  <= idx_o;
        end
    end

endmodule

// File: rtl/snitch_icache_lookup_arbiter.sv
// Shares one lookup stage between NR_PORTS L0 requesters: round-robin issue,
// index-based response routing, bounded outstanding count and sequenced flush.
module snitch_icache_lookup_arbiter
    import snitch_icache_pkg::*;
#(
    parameter int unsigned  NR_PORTS        = NR_PORTS_DEF,
    parameter int unsigned  FETCH_AW        = FETCH_AW_DEF,
    parameter int unsigned  ID_WIDTH        = ID_WIDTH_DEF,
    parameter int unsigned  LINE_WIDTH      = LINE_WIDTH_DEF,
    parameter int unsigned  SET_ALIGN       = SET_ALIGN_DEF,
    parameter int unsigned  MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    localparam int unsigned PAW             = port_aw(NR_PORTS),
    localparam int unsigned LIDW            = ID_WIDTH + PAW,
    localparam int unsigned CW              = cnt_w(MAX_OUTSTANDING)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,

    input  logic [NR_PORTS-1:0][FETCH_AW-1:0]  req_addr_i,
    input  logic [NR_PORTS-1:0][ID_WIDTH-1:0]  req_id_i,
    input  logic [NR_PORTS-1:0]                req_valid_i,
    output logic [NR_PORTS-1:0]                req_ready_o,

    output logic [FETCH_AW-1:0]                rsp_addr_o,
    output logic [ID_WIDTH-1:0]                rsp_id_o,
    output logic [SET_ALIGN-1:0]               rsp_set_o,
    output logic                               rsp_hit_o,
    output logic [LINE_WIDTH-1:0]              rsp_data_o,
    output logic                               rsp_error_o,
    output logic [NR_PORTS-1:0]                rsp_valid_o,
    input  logic [NR_PORTS-1:0]                rsp_ready_i,

    output logic [FETCH_AW-1:0]                lkp_addr_o,
    output logic [LIDW-1:0]                    lkp_id_o,
    output logic                               lkp_valid_o,
    input  logic                               lkp_ready_i,

    input  logic [FETCH_AW-1:0]                lkp_addr_i,
    input  logic [LIDW-1:0]                    lkp_id_i,
    input  logic [SET_ALIGN-1:0]               lkp_set_i,
    input  logic                               lkp_hit_i,
    input  logic [LINE_WIDTH-1:0]              lkp_data_i,
    input  logic                               lkp_error_i,
    input  logic                               lkp_valid_i,
    output logic                               lkp_ready_o,

    input  logic                               flush_valid_i,
    output logic                               flush_ready_o,
    output logic                               lkp_flush_valid_o,
    input  logic                               lkp_flush_ready_i
);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    flush_state_e        state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                arb_en, arb_valid;
    logic [NR_PORTS-1:0] arb_gnt;
    logic [PAW-1:0]      arb_idx;
    logic                req_hs, rsp_hs;
    logic [PAW-1:0]      rsp_port;
    logic                rsp_port_ok;

    // Request side: grants only while idle and below the outstanding bound.
    assign arb_en = (state_q == IDLE) && (cnt_q < CNT_MAX);

    snitch_icache_rr_arb #(
        .NR_PORTS (NR_PORTS)
    ) i_rr_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (arb_en),
        .valid_i (req_valid_i),
        .stall_i (arb_valid & ~lkp_ready_i),
        .hs_i    (req_hs),
        .valid_o (arb_valid),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx)
    );

    assign lkp_valid_o = arb_valid;
    assign lkp_addr_o  = req_addr_i[arb_idx];
    assign lkp_id_o    = {arb_idx, req_id_i[arb_idx]};
    assign req_ready_o = arb_gnt & {NR_PORTS{lkp_ready_i}};
    assign req_hs      = lkp_valid_o & lkp_ready_i;

    // Response side: the port index travels in the upper ID bits.
    assign rsp_port    = lkp_id_i[LIDW-1:ID_WIDTH];
    assign rsp_port_ok = int'(rsp_port) < int'(NR_PORTS);

    always_comb begin
        rsp_valid_o = '0;
        if (lkp_valid_i && rsp_port_ok) rsp_valid_o[rsp_port] = 1'b1;
    end

    assign lkp_ready_o = rsp_port_ok & rsp_ready_i[rsp_port];
    assign rsp_hs      = lkp_valid_i & lkp_ready_o;

    assign rsp_addr_o  = lkp_addr_i;
    assign rsp_id_o    = lkp_id_i[ID_WIDTH-1:0];
    assign rsp_set_o   = lkp_set_i;
    assign rsp_hit_o   = lkp_hit_i;
    assign rsp_data_o  = lkp_data_i;
    assign rsp_error_o = lkp_error_i;

    always_comb begin
        cnt_d = cnt_q;
        if (req_hs && !rsp_hs)      cnt_d = cnt_q + CW'(1);
        else if (!req_hs && rsp_hs) cnt_d = cnt_q - CW'(1);
    end

    // Drain uses the post-update count so the last response and the
    // move to FLUSH land on the same edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (flush_valid_i)     state_d = DRAIN;
            DRAIN:   if (cnt_d == '0)       state_d = FLUSH;
            FLUSH:   if (lkp_flush_ready_i) state_d = DONE;
            DONE:                           state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    assign lkp_flush_valid_o = (state_q == FLUSH);
    assign flush_ready_o     = (state_q == DONE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CNT_MAX);
    a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(cnt_q == '0 && rsp_hs && !req_hs));
    a_rsp_port: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lkp_valid_i |-> rsp_port_ok);

endmodule

// File: tb/tb_snitch_icache_lookup_arbiter.sv
// Random traffic against a cycle-level reference of the arbiter rules;
// expectations are queued per cycle and checked by an independent monitor.
module tb_snitch_icache_lookup_arbiter;
    import snitch_icache_pkg::*;

    localparam int NP   = 4;
    localparam int AW   = 32;
    localparam int IW   = 2;
    localparam int LW   = 128;
    localparam int SW   = 2;
    localparam int MO   = 2;
    localparam int PAW  = 2;
    localparam int LIDW = IW + PAW;
    localparam int NCYC = 3000;

    localparam int PH_IDLE = 0, PH_DRAIN = 1, PH_FLUSH = 2, PH_DONE = 3;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0][AW-1:0] req_addr_i;
    logic [NP-1:0][IW-1:0] req_id_i;
    logic [NP-1:0]         req_valid_i, req_ready_o;
    logic [AW-1:0]         rsp_addr_o;
    logic [IW-1:0]         rsp_id_o;
    logic [SW-1:0]         rsp_set_o;
    logic                  rsp_hit_o, rsp_error_o;
    logic [LW-1:0]         rsp_data_o;
    logic [NP-1:0]         rsp_valid_o, rsp_ready_i;
    logic [AW-1:0]         lkp_addr_o, lkp_addr_i;
    logic [LIDW-1:0]       lkp_id_o, lkp_id_i;
    logic                  lkp_valid_o, lkp_ready_i;
    logic [SW-1:0]         lkp_set_i;
    logic                  lkp_hit_i, lkp_error_i, lkp_valid_i, lkp_ready_o;
    logic [LW-1:0]         lkp_data_i;
    logic                  flush_valid_i, flush_ready_o, lkp_flush_valid_o, lkp_flush_ready_i;

    snitch_icache_lookup_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_addr_i(req_addr_i), .req_id_i(req_id_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .rsp_addr_o(rsp_addr_o), .rsp_id_o(rsp_id_o), .rsp_set_o(rsp_set_o), .rsp_hit_o(rsp_hit_o),
        .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .lkp_addr_o(lkp_addr_o), .lkp_id_o(lkp_id_o), .lkp_valid_o(lkp_valid_o), .lkp_ready_i(lkp_ready_i),
        .lkp_addr_i(lkp_addr_i), .lkp_id_i(lkp_id_i), .lkp_set_i(lkp_set_i), .lkp_hit_i(lkp_hit_i),
        .lkp_data_i(lkp_data_i), .lkp_error_i(lkp_error_i), .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o),
        .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
        .lkp_flush_valid_o(lkp_flush_valid_o), .lkp_flush_ready_i(lkp_flush_ready_i)
    );

    typedef struct {
        bit              valid;
        logic [AW-1:0]   addr;
        logic [LIDW-1:0] id;
        logic [NP-1:0]   req_ready;
        logic [NP-1:0]   rsp_valid;
        bit              lkp_ready;
        bit              fl_valid;
        bit              fl_ready;
        int              cyc;
    } exp_t;

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [SW-1:0] set;
        bit            hit;
        logic [LW-1:0] data;
        bit            err;
    } rsp_t;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [LIDW-1:0] id;
    } lkp_t;

    exp_t exp_q[$];
    rsp_t rsp_q[$];
    lkp_t inflight[$];

    int n_chk = 0, n_pass = 0, cur_cyc = 0;

    // Reference state: next-priority port, held grant, outstanding count, flush phase.
    int rr, lock_port, outst, ph;
    bit locked;

    // Environment state.
    bit has_req [NP];
    bit acc [NP];
    bit rsp_busy, rsp_done, flush_pend, fl_done, mid_rst_done;

    task automatic chk(input string name, input int cyc, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    task automatic model_reset();
        rr = 0; lock_port = 0; outst = 0; ph = PH_IDLE; locked = 1'b0;
    endtask

    task automatic model_step(input int cyc);
        exp_t e;
        int   w, p, c;
        bit   found, elig, req_hs, rsp_hs;
        elig  = (ph == PH_IDLE) && (outst < MO);
        w     = 0;
        found = 1'b0;
        if (locked) begin
            w     = lock_port;
            found = req_valid_i[w];
        end else begin
            for (int k = 0; k < NP; k++) begin
                c = (rr + k) % NP;
                if (!found && req_valid_i[c]) begin found = 1'b1; w = c; end
            end
        end
        e.valid     = elig && found;
        e.addr      = req_addr_i[w];
        e.id        = {PAW'(w), req_id_i[w]};
        e.req_ready = '0;
        if (e.valid && lkp_ready_i) e.req_ready[w] = 1'b1;
        p           = int'(lkp_id_i[LIDW-1:IW]);
        e.rsp_valid = '0;
        if (lkp_valid_i) e.rsp_valid[p] = 1'b1;
        e.lkp_ready = rsp_ready_i[p];
        e.fl_valid  = (ph == PH_FLUSH);
        e.fl_ready  = (ph == PH_DONE);
        e.cyc       = cyc;
        exp_q.push_back(e);

        // Environment bookkeeping from what the DUT actually did.
        for (int k = 0; k < NP; k++) acc[k] = req_valid_i[k] && req_ready_o[k];
        if (rst_ni && lkp_valid_o && lkp_ready_i) inflight.push_back('{lkp_addr_o, lkp_id_o});
        rsp_done = lkp_valid_i && lkp_ready_o;
        fl_done  = flush_ready_o;

        req_hs = e.valid && lkp_ready_i;
        rsp_hs = lkp_valid_i && rsp_ready_i[p];
        if (!rst_ni) model_reset();
        else begin
            if (req_hs) begin
                locked = 1'b0;
                rr     = (w + 1) % NP;
            end else if (e.valid) begin
                locked    = 1'b1;
                lock_port = w;
            end
            outst = outst + int'(req_hs) - int'(rsp_hs);
            case (ph)
                PH_IDLE:  if (flush_valid_i) ph = PH_DRAIN;
                PH_DRAIN: if (outst == 0) ph = PH_FLUSH;
                PH_FLUSH: if (lkp_flush_ready_i) ph = PH_DONE;
                default:  ph = PH_IDLE;
            endcase
        end
    endtask

    task automatic drive(input int cyc);
        bit   do_rst, fast;
        rsp_t r;
        fast   = (cyc < 300);
        do_rst = (!mid_rst_done && cyc > 800 && ph == PH_DRAIN && outst == 1) ||
                 (!mid_rst_done && cyc == 2200);
        if (do_rst) begin
            mid_rst_done = 1'b1;
            rst_ni       = 1'b0;
            for (int k = 0; k < NP; k++) has_req[k] = 1'b0;
            req_valid_i   = '0;
            lkp_valid_i   = 1'b0;
            rsp_busy      = 1'b0;
            flush_pend    = 1'b0;
            flush_valid_i = 1'b0;
            inflight.delete();
            rsp_q.delete();
            return;
        end
        rst_ni = 1'b1;

        // Requesters: hold each request until accepted; early phase uses ports 0 and 2 only.
        for (int k = 0; k < NP; k++) begin
            if (acc[k]) has_req[k] = 1'b0;
            if (!has_req[k] && (!fast || k == 0 || k == 2) && $urandom_range(0, 2) != 0) begin
                has_req[k]     = 1'b1;
                req_addr_i[k]  = $urandom;
                req_id_i[k]    = IW'($urandom);
            end
            req_valid_i[k] = has_req[k];
        end
        lkp_ready_i = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
        for (int k = 0; k < NP; k++) rsp_ready_i[k] = fast ? 1'b1 : ($urandom_range(0, 3) != 0);

        // Lookup stage: answers issued lookups in order after a random delay.
        if (rsp_done) begin
            rsp_busy = 1'b0;
            void'(inflight.pop_front());
        end
        if (!rsp_busy && inflight.size() > 0 && (fast || $urandom_range(0, 2) == 0)) begin
            rsp_busy    = 1'b1;
            lkp_addr_i  = inflight[0].addr;
            lkp_id_i    = inflight[0].id;
            lkp_set_i   = SW'($urandom);
            lkp_hit_i   = 1'($urandom);
            lkp_error_i = 1'($urandom);
            lkp_data_i  = {$urandom, $urandom, $urandom, $urandom};
            r.port = int'(lkp_id_i[LIDW-1:IW]);
            r.addr = lkp_addr_i; r.id = lkp_id_i[IW-1:0]; r.set = lkp_set_i;
            r.hit  = lkp_hit_i;  r.data = lkp_data_i;     r.err = lkp_error_i;
            rsp_q.push_back(r);
        end
        lkp_valid_i = rsp_busy;

        if (fl_done) flush_pend = 1'b0;
        if (!flush_pend && !fast && $urandom_range(0, 79) == 0) flush_pend = 1'b1;
        flush_valid_i     = flush_pend;
        lkp_flush_ready_i = 1'($urandom);
    endtask

    // Monitor: pops the per-cycle expectations and the response scoreboard.
    always @(negedge clk) begin
        exp_t          e;
        rsp_t          r;
        logic [NP-1:0] oh;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("lkp_valid_o", e.cyc, LW'(lkp_valid_o), LW'(e.valid));
            if (e.valid) begin
                chk("lkp_addr_o", e.cyc, LW'(lkp_addr_o), LW'(e.addr));
                chk("lkp_id_o", e.cyc, LW'(lkp_id_o), LW'(e.id));
            end
            chk("req_ready_o", e.cyc, LW'(req_ready_o), LW'(e.req_ready));
            chk("rsp_valid_o", e.cyc, LW'(rsp_valid_o), LW'(e.rsp_valid));
            chk("lkp_ready_o", e.cyc, LW'(lkp_ready_o), LW'(e.lkp_ready));
            chk("lkp_flush_valid_o", e.cyc, LW'(lkp_flush_valid_o), LW'(e.fl_valid));
            chk("flush_ready_o", e.cyc, LW'(flush_ready_o), LW'(e.fl_ready));
        end
        if (rst_ni && |(rsp_valid_o & rsp_ready_i)) begin
            chk("rsp_scoreboard_nonempty", cur_cyc, LW'(rsp_q.size() != 0), LW'(1));
            if (rsp_q.size() != 0) begin
                r  = rsp_q.pop_front();
                oh = '0;
                oh[r.port] = 1'b1;
                chk("rsp_port", cur_cyc, LW'(rsp_valid_o), LW'(oh));
                chk("rsp_addr_o", cur_cyc, LW'(rsp_addr_o), LW'(r.addr));
                chk("rsp_id_o", cur_cyc, LW'(rsp_id_o), LW'(r.id));
                chk("rsp_set_o", cur_cyc, LW'(rsp_set_o), LW'(r.set));
                chk("rsp_hit_o", cur_cyc, LW'(rsp_hit_o), LW'(r.hit));
                chk("rsp_data_o", cur_cyc, rsp_data_o, r.data);
                chk("rsp_error_o", cur_cyc, LW'(rsp_error_o), LW'(r.err));
            end
        end
    end

    initial begin
        req_addr_i = '0; req_id_i = '0; req_valid_i = '0; rsp_ready_i = '0;
        lkp_ready_i = 1'b0; lkp_addr_i = '0; lkp_id_i = '0; lkp_set_i = '0;
        lkp_hit_i = 1'b0; lkp_data_i = '0; lkp_error_i = 1'b0; lkp_valid_i = 1'b0;
        flush_valid_i = 1'b0; lkp_flush_ready_i = 1'b0;
        for (int k = 0; k < NP; k++) begin has_req[k] = 1'b0; acc[k] = 1'b0; end
        rsp_busy = 1'b0; rsp_done = 1'b0; flush_pend = 1'b0; fl_done = 1'b0; mid_rst_done = 1'b0;
        model_reset();
        rst_ni = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            cur_cyc = cyc;
            @(negedge clk);
            model_step(cyc);
            @(posedge clk);
            #1;
            drive(cyc);
        end
        @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
